shift_right_register_serial_receiver: RTL

Serial-in, parallel-out receiver that reassembles words produced by the circular shift-right transmitter (which emits bit 0 first from its last stage). Bits arrive LSB-first on `data`, qualified by `shift_enable`, with `start` marking the first bit of each frame. Completed words go to a holding register with a valid/read handshake and a sticky overrun flag. The block sits at the receiving end of the serial link, feeding parallel consumers in the datapath.

---
 rtl/shift_right_register_serial_receiver_pkg.sv | 22 ++
 rtl/shift_right_register_serial_receiver_if.sv | 23 ++
 rtl/shift_right_register_serial_receiver_receiver_bit_counter.sv | 26 ++
 rtl/shift_right_register_serial_receiver.sv | 91 +++++++++
 4 files changed

// File: rtl/shift_right_register_serial_receiver_pkg.sv
// Shared definitions for the serial receiver: state encodings, default word
// width and the bit-counter width helper. Guarded so it can be pulled in more than once.
`ifndef SHIFT_RIGHT_REGISTER_SERIAL_RECEIVER_PKG_SV
`define SHIFT_RIGHT_REGISTER_SERIAL_RECEIVER_PKG_SV

package shift_right_register_serial_receiver_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } rx_state_e;

    localparam int DEFAULT_WIDTH = 5;

    // Bits needed to count 0..width-1; never less than one.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

`endif

// File: rtl/shift_right_register_serial_receiver_if.sv
// Serial input strobes plus the parallel word/handshake side of the receiver.
interface shift_right_register_serial_receiver_if #(
    parameter int WIDTH = shift_right_register_serial_receiver_pkg::DEFAULT_WIDTH
);
    logic             data;
    logic             shift_enable;
    logic             start;
    logic             read;
    logic [WIDTH-1:0] word;
    logic             valid;
    logic             overrun;
    logic             busy;

    modport master (
        output data, shift_enable, start, read,
        input  word, valid, overrun, busy
    );

    modport slave (
        input  data, shift_enable, start, read,
        output word, valid, overrun, busy
    );
endinterface

// File: rtl/shift_right_register_serial_receiver_receiver_bit_counter.sv
// Modulo-WIDTH bit counter for the serial receiver; flags the bit that completes a word.
module receiver_bit_counter #(
    parameter int WIDTH = 5,
    parameter int CW    = 3
) (
    input  logic clock,
    input  logic clear,
    input  logic inc,
    input  logic load_one,
    output logic last
);
    logic [CW-1:0] count_reg;

    assign last = (count_reg == CW'(WIDTH - 1));

    // A start bit always counts as bit 0 already received, hence load of 1.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count_reg <= '0;
        end else if (load_one) begin
            count_reg <= CW'(1);
        end else if (inc) begin
            count_reg <= last ? '0 : count_reg + CW'(1);
        end
    end
endmodule

// File: rtl/shift_right_register_serial_receiver.sv
// LSB-first serial-to-parallel receiver with frame sync, holding register,
// valid/read handshake and sticky overrun.
module shift_right_register_serial_receiver
    import shift_right_register_serial_receiver_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clock,
    input  logic clear,
    shift_right_register_serial_receiver_if.slave rx
);
    localparam int CW = cnt_width(WIDTH);

    rx_state_e        state_reg;
    // Only the newest WIDTH-1 bits are kept; the oldest one would be shifted
    // out by the next bit anyway, so the full word is formed from shift_next.
    logic [WIDTH-2:0] sr_reg;
    logic [WIDTH-1:0] word_reg;
    logic             valid_reg;
    logic             overrun_reg;

    logic [WIDTH-1:0] shift_next;
    logic             cnt_inc;
    logic             cnt_load;
    logic             cnt_last;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign shift_next[gi] = sr_reg[gi];
        end
    endgenerate
    assign shift_next[WIDTH-1] = rx.data;

    assign cnt_load = rx.shift_enable & rx.start;
    assign cnt_inc  = rx.shift_enable & ~rx.start & (state_reg == RECEIVE);

    receiver_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bit_counter (
        .clock    (clock),
        .clear    (clear),
        .inc      (cnt_inc),
        .load_one (cnt_load),
        .last     (cnt_last)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg   <= IDLE;
            sr_reg      <= '0;
            word_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (rx.read && valid_reg) begin
                valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (rx.shift_enable && rx.start) begin
                        sr_reg    <= shift_next[WIDTH-1:1];
                        state_reg <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (rx.shift_enable) begin
                        sr_reg <= shift_next[WIDTH-1:1];
                        if (!rx.start && cnt_last) begin
                            word_reg  <= shift_next;
                            valid_reg <= 1'b1;
                            // A read landing on the completion edge frees the slot in time.
                            if (valid_reg && !rx.read) begin
                                overrun_reg <= 1'b1;
                            end
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rx.word    = word_reg;
    assign rx.valid   = valid_reg;
    assign rx.overrun = overrun_reg;
    assign rx.busy    = (state_reg == RECEIVE);
endmodule
